// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between the pipeline datapath and its freeze/flush sequencer.
// The master side owns the hazard/branch/memory status; the slave side owns the controls.
interface pipeline_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             hazard_Detected;
  logic             Br_taken;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_bubble;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             mem_wb_bubble;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             mem_timeout;

  modport master (
    output hazard_Detected, Br_taken, mem_req, mem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
           ex_mem_en, mem_wb_en, mem_wb_bubble, state,
           stall_cnt, flush_cnt, mem_timeout
  );

  modport slave (
    input  hazard_Detected, Br_taken, mem_req, mem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
           ex_mem_en, mem_wb_en, mem_wb_bubble, state,
           stall_cnt, flush_cnt, mem_timeout
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Freeze/flush controller for the 5-stage pipeline: per-stage enables, IF/ID flush,
// bubbles, multi-slot branch flush sequencing, stall/flush counters and a memory watchdog.
module pipeline_sequencer #(
  parameter int FLUSH_SLOTS = 1,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1
  } state_t;

  localparam int             WD_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(MEM_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);
  localparam logic [3:0]     REM_INIT = 4'(FLUSH_SLOTS - 1);

  state_t           state_q, state_d;
  logic [3:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic [WD_W-1:0]  wd_q;
  logic             timeout_q;
  logic             mem_stall;
  logic             stall_inc;
  logic             br_accept;

  assign mem_stall = bus.mem_req & ~bus.mem_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d           = state_q;
    rem_d             = rem_q;
    stall_inc         = 1'b0;
    br_accept         = 1'b0;
    bus.pc_en         = 1'b1;
    bus.if_id_en      = 1'b1;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_en      = 1'b1;
    bus.id_ex_bubble  = 1'b0;
    bus.ex_mem_en     = 1'b1;
    bus.mem_wb_en     = 1'b1;
    bus.mem_wb_bubble = 1'b0;

    if (mem_stall) begin
      // Whole pipe freezes; MEM/WB drains a bubble so WB never repeats an instruction.
      bus.pc_en         = 1'b0;
      bus.if_id_en      = 1'b0;
      bus.id_ex_en      = 1'b0;
      bus.ex_mem_en     = 1'b0;
      bus.mem_wb_bubble = 1'b1;
      stall_inc         = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.hazard_Detected) begin
            // Branch operands are stale under a hazard, so Br_taken waits for the replay.
            bus.pc_en        = 1'b0;
            bus.if_id_en     = 1'b0;
            bus.id_ex_bubble = 1'b1;
            stall_inc        = 1'b1;
          end else if (bus.Br_taken) begin
            bus.if_id_flush = 1'b1;
            br_accept       = 1'b1;
            if (FLUSH_SLOTS > 1) begin
              state_d = FLUSH;
              rem_d   = REM_INIT;
            end
          end
        end
        FLUSH: begin
          bus.if_id_flush = 1'b1;
          rem_d           = rem_q - 4'd1;
          if (rem_d == 4'd0) state_d = RUN;
        end
        default: begin
          state_d = RUN;
          rem_d   = 4'd0;
        end
      endcase
    end

    if (rst) begin
      bus.pc_en         = 1'b0;
      bus.if_id_en      = 1'b0;
      bus.if_id_flush   = 1'b0;
      bus.id_ex_en      = 1'b0;
      bus.id_ex_bubble  = 1'b0;
      bus.ex_mem_en     = 1'b0;
      bus.mem_wb_en     = 1'b0;
      bus.mem_wb_bubble = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      rem_q       <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wd_q        <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (stall_inc && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (br_accept && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (!mem_stall)          wd_q <= '0;
      else if (wd_q != WD_MAX) wd_q <= wd_q + WD_W'(1);
      if (mem_stall && wd_q >= WD_LAST) timeout_q <= 1'b1;
    end
  end

  assign bus.state       = state_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
  assign bus.mem_timeout = timeout_q;

endmodule
